// File: rtl/fht_stage_feeder_if.sv
`default_nettype none
// ============================================================================
// Module      : fht_stage_feeder_if
// Description : Bundle of every non-clock/reset signal of fht_stage_feeder:
//               stage control (start/stage/busy/done), the three-port source
//               bank read side, the twiddle ROM, the operand set sent to the
//               butterfly, the butterfly results and the two-port
//               destination bank write side.
//               modport master : the feeder (drives every o* signal)
//               modport slave  : the environment (controller, banks, ROM,
//                                butterfly; drives every i* signal)
// Revision    : 1.0 - initial release
// ============================================================================
interface fht_stage_feeder_if #(
    parameter int LOG2N = 8,
    parameter int D_BIT = 17,
    parameter int W_BIT = 12
);
    localparam int STG_W = (LOG2N > 1) ? $clog2(LOG2N) : 1;

    // Stage control
    logic                     iSTART;
    logic [STG_W-1:0]         iSTAGE;
    logic                     oBUSY;
    logic                     oDONE;

    // Source bank, three synchronous read ports
    logic [LOG2N-1:0]         oRD_ADDR_0;
    logic [LOG2N-1:0]         oRD_ADDR_1;
    logic [LOG2N-1:0]         oRD_ADDR_2;
    logic signed [D_BIT-1:0]  iRD_DATA_0;
    logic signed [D_BIT-1:0]  iRD_DATA_1;
    logic signed [D_BIT-1:0]  iRD_DATA_2;

    // Twiddle ROM
    logic [LOG2N-2:0]         oROM_ADDR;
    logic signed [W_BIT-1:0]  iSIN;
    logic signed [W_BIT-1:0]  iCOS;

    // Butterfly operand set
    logic signed [D_BIT-1:0]  oX_0;
    logic signed [D_BIT-1:0]  oX_1;
    logic signed [D_BIT-1:0]  oX_2;
    logic signed [W_BIT-1:0]  oSIN;
    logic signed [W_BIT-1:0]  oCOS;
    logic                     oBUT_VALID;

    // Butterfly results
    logic signed [D_BIT-1:0]  iY_0;
    logic signed [D_BIT-1:0]  iY_1;

    // Destination bank, two write ports sharing one strobe
    logic [LOG2N-1:0]         oWR_ADDR_0;
    logic [LOG2N-1:0]         oWR_ADDR_1;
    logic signed [D_BIT-1:0]  oWR_DATA_0;
    logic signed [D_BIT-1:0]  oWR_DATA_1;
    logic                     oWR_EN;

    modport master (
        input  iSTART, iSTAGE,
        input  iRD_DATA_0, iRD_DATA_1, iRD_DATA_2,
        input  iSIN, iCOS,
        input  iY_0, iY_1,
        output oBUSY, oDONE,
        output oRD_ADDR_0, oRD_ADDR_1, oRD_ADDR_2,
        output oROM_ADDR,
        output oX_0, oX_1, oX_2, oSIN, oCOS, oBUT_VALID,
        output oWR_ADDR_0, oWR_ADDR_1, oWR_DATA_0, oWR_DATA_1, oWR_EN
    );

    modport slave (
        output iSTART, iSTAGE,
        output iRD_DATA_0, iRD_DATA_1, iRD_DATA_2,
        output iSIN, iCOS,
        output iY_0, iY_1,
        input  oBUSY, oDONE,
        input  oRD_ADDR_0, oRD_ADDR_1, oRD_ADDR_2,
        input  oROM_ADDR,
        input  oX_0, oX_1, oX_2, oSIN, oCOS, oBUT_VALID,
        input  oWR_ADDR_0, oWR_ADDR_1, oWR_DATA_0, oWR_DATA_1, oWR_EN
    );
endinterface
`default_nettype wire

// File: rtl/fht_stage_feeder.sv
`default_nettype none
// ============================================================================
// Module      : fht_stage_feeder
// Description : Operand sequencer for one radix-2 FHT stage. On an accepted
//               start it walks the N/2 butterflies of stage s (group outer,
//               in-group index inner), issues three source-bank read
//               addresses plus a twiddle ROM index per cycle, forwards the
//               returned data as one operand set per cycle to the butterfly,
//               and writes the butterfly results back to the other bank.
//
//               Optional build macro FHT_FEED_BITREV_EN: when defined, stage
//               0 reads use the LOG2N-bit bit-reversed addresses (input
//               reordering folded into the first stage); writes stay in
//               natural order. Undefined: natural order everywhere.
//
// Ports       : iCLK        - clock, rising edge
//               iRESET      - asynchronous reset, active low
//               bus (master)- start/stage/busy/done, 3 read ports, ROM,
//                             butterfly operands/results, 2 write ports
//
// Pipeline (b = butterfly index, cycle 0 = START sampled):
//               1+b         read / ROM addresses
//               2+b         read / ROM data returned
//               3+b         operand set to butterfly
//               3+BUT_LAT+b butterfly results returned
//               4+BUT_LAT+b write address / data / strobe
//
// Revision    : 1.0 - initial release
// ============================================================================
module fht_stage_feeder #(
    parameter int LOG2N   = 8,
    parameter int D_BIT   = 17,
    parameter int W_BIT   = 12,
    parameter int BUT_LAT = 2
) (
    input  logic               iCLK,
    input  logic               iRESET,
    fht_stage_feeder_if.master bus
);

    localparam int STG_W = (LOG2N > 1) ? $clog2(LOG2N) : 1;
    // Write address / valid travel from the read-address register to the
    // write-output register: DEPTH shifts.
    localparam int DEPTH = 3 + BUT_LAT;

    localparam logic [LOG2N-1:0] ONE        = LOG2N'(1);
    localparam logic [LOG2N-1:0] LAST_B     = LOG2N'((1 << (LOG2N - 1)) - 1);
    localparam logic [STG_W-1:0] LAST_STAGE = STG_W'(LOG2N - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [LOG2N-1:0]   bcnt;
    logic [LOG2N-1:0]   bcnt_nxt;
    logic [STG_W-1:0]   stage_q;
    logic               issue;

    logic [LOG2N-1:0]   cur_b;
    logic [STG_W-1:0]   cur_s;
    logic               last_b;

    // Address generation
    logic [LOG2N-1:0]   half;
    logic [LOG2N-1:0]   mask;
    logic [LOG2N-1:0]   k;
    logic [LOG2N-1:0]   g;
    logic [LOG2N-1:0]   x0_nat;
    logic [LOG2N-1:0]   x1_nat;
    logic [LOG2N-1:0]   x2_nat;
    logic [LOG2N-1:0]   rd0_nxt;
    logic [LOG2N-1:0]   rd1_nxt;
    logic [LOG2N-1:0]   rd2_nxt;
    logic [LOG2N-2:0]   rom_nxt;

    // Issue stage registers
    logic [LOG2N-1:0]   rd_addr_0;
    logic [LOG2N-1:0]   rd_addr_1;
    logic [LOG2N-1:0]   rd_addr_2;
    logic [LOG2N-2:0]   rom_addr;

    // Write-address / valid shift register; index 0 is the issue stage
    logic [DEPTH:0]     vld;
    logic [LOG2N-1:0]   wa0 [0:DEPTH];
    logic [LOG2N-1:0]   wa1 [0:DEPTH];

    // Data path registers
    logic signed [D_BIT-1:0] x_0;
    logic signed [D_BIT-1:0] x_1;
    logic signed [D_BIT-1:0] x_2;
    logic signed [W_BIT-1:0] sin_q;
    logic signed [W_BIT-1:0] cos_q;
    logic signed [D_BIT-1:0] wr_data_0;
    logic signed [D_BIT-1:0] wr_data_1;

`ifdef FHT_FEED_BITREV_EN
    function automatic logic [LOG2N-1:0] bit_rev(input logic [LOG2N-1:0] a);
        logic [LOG2N-1:0] r;
        r = '0;
        for (int i = 0; i < LOG2N; i++) begin
            r[i] = a[LOG2N-1-i];
        end
        return r;
    endfunction
`endif

    // The first butterfly is issued in the same cycle START is accepted, so
    // while idle the index is forced to 0 and the stage comes straight from
    // the input; afterwards both come from registers.
    assign cur_b  = (state == S_IDLE) ? '0 : bcnt;
    assign cur_s  = (state == S_IDLE) ? bus.iSTAGE : stage_q;
    assign last_b = (cur_b == LAST_B);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            state   <= S_IDLE;
            bcnt    <= '0;
            stage_q <= '0;
        end else begin
            state <= state_nxt;
            bcnt  <= bcnt_nxt;
            if ((state == S_IDLE) && bus.iSTART) begin
                stage_q <= bus.iSTAGE;
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and issue strobe
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        bcnt_nxt  = bcnt;
        issue     = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.iSTART) begin
                    issue     = 1'b1;
                    bcnt_nxt  = ONE;
                    state_nxt = last_b ? S_DRAIN : S_ISSUE;
                end
            end
            S_ISSUE: begin
                issue    = 1'b1;
                bcnt_nxt = bcnt + ONE;
                if (last_b) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Leave when only the write-output stage may still hold a
                // valid entry: that last write lands in this cycle, so the
                // DONE cycle sees an empty pipeline.
                if (vld[DEPTH-1:0] == '0) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                bcnt_nxt  = '0;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Address generation for butterfly cur_b of stage cur_s.
    // half = H, k = b mod H, g = (b div H) * 2H; since H is a power of two
    // these are a mask and a shift of b.
    // ------------------------------------------------------------------
    always_comb begin
        half   = ONE << cur_s;
        mask   = half - ONE;
        k      = cur_b & mask;
        g      = (cur_b & ~mask) << 1;
        x0_nat = g + k;
        x1_nat = g + half + k;
        // At the last stage 2H wraps to 0 in LOG2N bits, which still gives
        // the correct g + L - k modulo N.
        x2_nat = (k == '0) ? (g + half) : (g + (half << 1) - k);
        // k < H <= N/2, so its MSB is always zero.
        rom_nxt = k[LOG2N-2:0] << (LAST_STAGE - cur_s);
        rd0_nxt = x0_nat;
        rd1_nxt = x1_nat;
        rd2_nxt = x2_nat;
`ifdef FHT_FEED_BITREV_EN
        if (cur_s == '0) begin
            rd0_nxt = bit_rev(x0_nat);
            rd1_nxt = bit_rev(x1_nat);
            rd2_nxt = bit_rev(x2_nat);
        end
`endif
    end

    // ------------------------------------------------------------------
    // Issue stage and write-address pipeline
    // ------------------------------------------------------------------
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            vld       <= '0;
            rd_addr_0 <= '0;
            rd_addr_1 <= '0;
            rd_addr_2 <= '0;
            rom_addr  <= '0;
            for (int j = 0; j <= DEPTH; j++) begin
                wa0[j] <= '0;
                wa1[j] <= '0;
            end
        end else begin
            vld <= {vld[DEPTH-1:0], issue};
            if (issue) begin
                rd_addr_0 <= rd0_nxt;
                rd_addr_1 <= rd1_nxt;
                rd_addr_2 <= rd2_nxt;
                rom_addr  <= rom_nxt;
                wa0[0]    <= x0_nat;
                wa1[0]    <= x1_nat;
            end
            for (int j = 1; j <= DEPTH; j++) begin
                wa0[j] <= wa0[j-1];
                wa1[j] <= wa1[j-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Data path: pure pass-through, captured only when the matching
    // pipeline slot is valid so idle cycles keep the outputs stable.
    // vld[1]       : read / ROM data present at the inputs
    // vld[DEPTH-1] : butterfly results present at the inputs
    // ------------------------------------------------------------------
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            x_0       <= '0;
            x_1       <= '0;
            x_2       <= '0;
            sin_q     <= '0;
            cos_q     <= '0;
            wr_data_0 <= '0;
            wr_data_1 <= '0;
        end else begin
            if (vld[1]) begin
                x_0   <= bus.iRD_DATA_0;
                x_1   <= bus.iRD_DATA_1;
                x_2   <= bus.iRD_DATA_2;
                sin_q <= bus.iSIN;
                cos_q <= bus.iCOS;
            end
            if (vld[DEPTH-1]) begin
                wr_data_0 <= bus.iY_0;
                wr_data_1 <= bus.iY_1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs (all driven from registers)
    // ------------------------------------------------------------------
    assign bus.oBUSY      = (state != S_IDLE);
    assign bus.oDONE      = (state == S_DONE);
    assign bus.oRD_ADDR_0 = rd_addr_0;
    assign bus.oRD_ADDR_1 = rd_addr_1;
    assign bus.oRD_ADDR_2 = rd_addr_2;
    assign bus.oROM_ADDR  = rom_addr;
    assign bus.oX_0       = x_0;
    assign bus.oX_1       = x_1;
    assign bus.oX_2       = x_2;
    assign bus.oSIN       = sin_q;
    assign bus.oCOS       = cos_q;
    assign bus.oBUT_VALID = vld[2];
    assign bus.oWR_ADDR_0 = wa0[DEPTH];
    assign bus.oWR_ADDR_1 = wa1[DEPTH];
    assign bus.oWR_DATA_0 = wr_data_0;
    assign bus.oWR_DATA_1 = wr_data_1;
    assign bus.oWR_EN     = vld[DEPTH];

endmodule
`default_nettype wire
